// File: rtl/window_3x3.sv
`default_nettype none
// ============================================================================
//  Module   : window_3x3
//  Purpose  : 3x3 sliding window over a square image delivered as 3-row
//             columns. Optional macro WINDOW_FRAME_DONE_EN adds frame_done_o.
//  Revision : 1.0  initial release
// ============================================================================
module window_3x3 #(
   parameter int DATA_W = 8,
   parameter int SIZE_W = 9
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SIZE_W-1:0]   IMG_SIZE_I,
   input  logic [DATA_W-1:0]   row0_i,
   input  logic [DATA_W-1:0]   row1_i,
   input  logic [DATA_W-1:0]   row2_i,
   input  logic                valid_i,
   output logic                ready_o,
   output logic [9*DATA_W-1:0] window_o,
   output logic                window_valid_o
`ifdef WINDOW_FRAME_DONE_EN
   ,
   output logic                frame_done_o
`endif
);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_run  = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   localparam logic [SIZE_W-1:0] c_one   = SIZE_W'(1);
   localparam logic [SIZE_W-1:0] c_two   = SIZE_W'(2);
   localparam logic [SIZE_W-1:0] c_three = SIZE_W'(3);

   logic [1:0]          r_state;
   logic [SIZE_W-1:0]   r_size;
   logic [SIZE_W-1:0]   r_col_cnt;
   logic [SIZE_W-1:0]   r_row_cnt;
   // The oldest column (c0) only ever lives in the window register, so only
   // c1 and c2 are kept as separate column registers.
   logic [3*DATA_W-1:0] r_col1;
   logic [3*DATA_W-1:0] r_col2;
   logic [9*DATA_W-1:0] r_window;
   logic                r_window_valid;

   logic                w_beat;
   logic                w_size_ok;
   logic                w_last_col;
   logic                w_last_row;
   logic                w_win_col;
   logic [3*DATA_W-1:0] w_col_in;
   logic [9*DATA_W-1:0] w_window;

   assign ready_o    = (r_state != c_done);
   assign w_beat     = valid_i & ready_o;
   assign w_col_in   = {row2_i, row1_i, row0_i};
   assign w_size_ok  = (IMG_SIZE_I >= c_three);
   assign w_last_col = (r_col_cnt == (r_size - c_one));
   assign w_last_row = (r_row_cnt == (r_size - c_three));
   assign w_win_col  = (r_col_cnt >= c_two);

   // Window as it looks after the current beat's shift: c1, c2, new column.
   for (genvar r = 0; r < 3; r++) begin : g_row
      assign w_window[(3*r+0)*DATA_W +: DATA_W] = r_col1[r*DATA_W +: DATA_W];
      assign w_window[(3*r+1)*DATA_W +: DATA_W] = r_col2[r*DATA_W +: DATA_W];
      assign w_window[(3*r+2)*DATA_W +: DATA_W] = w_col_in[r*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= c_idle;
         r_size         <= '0;
         r_col_cnt      <= '0;
         r_row_cnt      <= '0;
         r_col1         <= '0;
         r_col2         <= '0;
         r_window       <= '0;
         r_window_valid <= 1'b0;
      end else begin
         r_window_valid <= 1'b0;
         case (r_state)
            c_idle: begin
               if (w_beat) begin
                  r_size <= IMG_SIZE_I;
                  // Images narrower than 3 cannot form a window: drop the beat.
                  if (w_size_ok) begin
                     r_col1    <= r_col2;
                     r_col2    <= w_col_in;
                     r_col_cnt <= c_one;
                     r_state   <= c_run;
                  end
               end
            end
            c_run: begin
               if (w_beat) begin
                  r_col1 <= r_col2;
                  r_col2 <= w_col_in;
                  if (w_win_col) begin
                     r_window       <= w_window;
                     r_window_valid <= 1'b1;
                  end
                  if (w_last_col) begin
                     r_col_cnt <= '0;
                     if (w_last_row) begin
                        r_row_cnt <= '0;
                        r_state   <= c_done;
                     end else begin
                        r_row_cnt <= r_row_cnt + c_one;
                     end
                  end else begin
                     r_col_cnt <= r_col_cnt + c_one;
                  end
               end
            end
            c_done: begin
               r_state   <= c_idle;
               r_col_cnt <= '0;
               r_row_cnt <= '0;
            end
            default: begin
               r_state <= c_idle;
            end
         endcase
      end
   end

   assign window_o       = r_window;
   assign window_valid_o = r_window_valid;

`ifdef WINDOW_FRAME_DONE_EN
   assign frame_done_o = (r_state == c_done);
`endif

endmodule
`default_nettype wire

// File: tb/tb_window_3x3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window_3x3
//  Purpose  : Self-checking bench for window_3x3 against a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_window_3x3;

   localparam int DATA_W = 8;
   localparam int SIZE_W = 9;

   logic                clk = 1'b0;
   logic                rst;
   logic [SIZE_W-1:0]   img_size;
   logic [DATA_W-1:0]   row0, row1, row2;
   logic                valid_i;
   logic                ready_o;
   logic [9*DATA_W-1:0] window_o;
   logic                window_valid_o;
`ifdef WINDOW_FRAME_DONE_EN
   logic                frame_done_o;
`endif

   window_3x3 #(.DATA_W(DATA_W), .SIZE_W(SIZE_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .IMG_SIZE_I     (img_size),
      .row0_i         (row0),
      .row1_i         (row1),
      .row2_i         (row2),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .window_o       (window_o),
      .window_valid_o (window_valid_o)
`ifdef WINDOW_FRAME_DONE_EN
      ,
      .frame_done_o   (frame_done_o)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   // Frame-level model: beats numbered within a frame give column = b % N and
   // row triple = b / N; a window exists once three columns of a row are in.
   bit                  m_known   = 1'b0;
   bit                  m_inframe = 1'b0;
   bit                  m_donecyc = 1'b0;
   int                  m_n       = 0;
   int                  m_beats   = 0;
   logic [DATA_W-1:0]   mcol [0:511][0:2];
   logic                exp_ready;
   logic                exp_wv;
   logic [9*DATA_W-1:0] exp_win;
`ifdef WINDOW_FRAME_DONE_EN
   logic                exp_done;
`endif

   int                  mon_wins;
   int                  mon_rdy_low;
   int                  mon_beats;
   int                  beats_at_first;
   logic [9*DATA_W-1:0] first_win;

   initial begin
      forever begin
         @(negedge clk);
         if (m_known) begin
            check("ready_o", 128'(ready_o), 128'(exp_ready));
            check("window_valid_o", 128'(window_valid_o), 128'(exp_wv));
            check("window_o", 128'(window_o), 128'(exp_win));
`ifdef WINDOW_FRAME_DONE_EN
            check("frame_done_o", 128'(frame_done_o), 128'(exp_done));
`endif
         end
         if (window_valid_o === 1'b1) begin
            if (mon_wins == 0) begin
               first_win      = window_o;
               beats_at_first = mon_beats;
            end
            mon_wins++;
         end
         if (ready_o === 1'b0) mon_rdy_low++;
         if (valid_i && ready_o) mon_beats++;

         // Predict the outputs after the coming rising edge.
         if (rst) begin
            m_known   = 1'b1;
            m_inframe = 1'b0;
            m_donecyc = 1'b0;
            m_beats   = 0;
            exp_ready = 1'b1;
            exp_wv    = 1'b0;
            exp_win   = '0;
`ifdef WINDOW_FRAME_DONE_EN
            exp_done  = 1'b0;
`endif
         end else if (m_known) begin
            exp_wv = 1'b0;
`ifdef WINDOW_FRAME_DONE_EN
            exp_done = 1'b0;
`endif
            if (m_donecyc) begin
               m_donecyc = 1'b0;
               m_inframe = 1'b0;
               m_beats   = 0;
               exp_ready = 1'b1;
            end else if (valid_i) begin
               if (!m_inframe) begin
                  m_n = int'(img_size);
                  if (m_n >= 3) begin
                     m_inframe = 1'b1;
                     m_beats   = 0;
                  end
               end
               if (m_inframe) begin
                  int col;
                  col = m_beats % m_n;
                  mcol[col][0] = row0;
                  mcol[col][1] = row1;
                  mcol[col][2] = row2;
                  if (col >= 2) begin
                     exp_wv = 1'b1;
                     for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                           exp_win[(r*3+c)*DATA_W +: DATA_W] = mcol[col-2+c][r];
                  end
                  m_beats++;
                  if (m_beats == m_n * (m_n - 2)) begin
                     m_donecyc = 1'b1;
                     exp_ready = 1'b0;
`ifdef WINDOW_FRAME_DONE_EN
                     exp_done  = 1'b1;
`endif
                  end
               end
            end
         end
      end
   end

   task automatic clear_mon();
      mon_wins       = 0;
      mon_rdy_low    = 0;
      mon_beats      = 0;
      beats_at_first = -1;
      first_win      = '0;
   endtask

   task automatic idle(input int k);
      valid_i = 1'b0;
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_beat(input logic [DATA_W-1:0] p0, input logic [DATA_W-1:0] p1,
                            input logic [DATA_W-1:0] p2);
      bit acc;
      acc     = 1'b0;
      row0    = p0;
      row1    = p1;
      row2    = p2;
      valid_i = 1'b1;
      for (int k = 0; k < 8 && !acc; k++) begin
         @(negedge clk);
         acc = ready_o;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         n_checks++;
         $display("FAIL beat_accept: ready_o never high within 8 cycles, required high");
      end
   endtask

   task automatic run_frame(input int n, input int nbeats, input bit formula, input int gap_max,
                            input int gap_at, input int gap_len, input int size_after);
      img_size = SIZE_W'(n);
      for (int i = 0; i < nbeats; i++) begin
         int t, col;
         logic [DATA_W-1:0] p0, p1, p2;
         t   = i / n;
         col = i % n;
         if (i == gap_at) idle(gap_len);
         if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
         if (formula) begin
            p0 = DATA_W'(t * n + col + 1);
            p1 = DATA_W'((t + 1) * n + col + 1);
            p2 = DATA_W'((t + 2) * n + col + 1);
         end else begin
            p0 = DATA_W'($urandom);
            p1 = DATA_W'($urandom);
            p2 = DATA_W'($urandom);
         end
         send_beat(p0, p1, p2);
         if (i == 0) img_size = SIZE_W'(size_after);
      end
      valid_i = 1'b0;
   endtask

   logic [9*DATA_W-1:0] lit_first;

   initial begin
      lit_first = {8'd13, 8'd12, 8'd11, 8'd8, 8'd7, 8'd6, 8'd3, 8'd2, 8'd1};
      rst      = 1'b1;
      valid_i  = 1'b0;
      img_size = '0;
      row0     = '0;
      row1     = '0;
      row2     = '0;
      clear_mon();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_ready", 128'(ready_o), 128'(1));
      check("reset_wvalid", 128'(window_valid_o), 128'(0));
      check("reset_window", 128'(window_o), 128'(0));
      @(posedge clk);
      #1;

      // N=5 back-to-back with row*5+col+1 pixels
      clear_mon();
      run_frame(5, 15, 1'b1, 0, -1, 0, 5);
      check("ready_after_last", 128'(ready_o), 128'(0));
`ifdef WINDOW_FRAME_DONE_EN
      check("frame_done_after_last", 128'(frame_done_o), 128'(1));
`endif
      idle(3);
      check("n5_windows", 128'(mon_wins), 128'(9));
      check("n5_first_window", 128'(first_win), 128'(lit_first));
      check("n5_first_latency", 128'(beats_at_first), 128'(3));
      check("n5_ready_low", 128'(mon_rdy_low), 128'(1));

      // 4-cycle gap between beats 2 and 3
      clear_mon();
      run_frame(5, 15, 1'b1, 0, 2, 4, 5);
      idle(3);
      check("gap_windows", 128'(mon_wins), 128'(9));
      check("gap_first_window", 128'(first_win), 128'(lit_first));
      check("gap_first_latency", 128'(beats_at_first), 128'(3));

      // size changes to 7 mid-frame: ignored until next frame
      clear_mon();
      run_frame(5, 15, 1'b0, 0, -1, 0, 7);
      check("resize_end_at_15", 128'(ready_o), 128'(0));
      idle(2);
      check("resize_windows5", 128'(mon_wins), 128'(9));
      clear_mon();
      run_frame(7, 35, 1'b0, 0, -1, 0, 7);
      check("n7_end_at_35", 128'(ready_o), 128'(0));
      idle(2);
      check("n7_windows", 128'(mon_wins), 128'(25));
      check("n7_ready_low", 128'(mon_rdy_low), 128'(1));

      // N=2: beats discarded
      clear_mon();
      run_frame(2, 10, 1'b0, 0, -1, 0, 2);
      idle(2);
      check("n2_windows", 128'(mon_wins), 128'(0));
      check("n2_ready_low", 128'(mon_rdy_low), 128'(0));

      // reset after beat 7, then a fresh frame
      clear_mon();
      run_frame(5, 7, 1'b1, 0, -1, 0, 5);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midreset_window", 128'(window_o), 128'(0));
      check("midreset_wvalid", 128'(window_valid_o), 128'(0));
      check("midreset_ready", 128'(ready_o), 128'(1));
      clear_mon();
      run_frame(5, 15, 1'b0, 0, -1, 0, 5);
      idle(3);
      check("post_reset_windows", 128'(mon_wins), 128'(9));

      // random sizes, gaps and pixels
      for (int f = 0; f < 6; f++) begin
         int n;
         n = int'($urandom_range(3, 8));
         clear_mon();
         run_frame(n, n * (n - 2), 1'b0, 2, -1, 0, int'($urandom_range(0, 9)));
         idle(3);
         check("rand_windows", 128'(mon_wins), 128'((n - 2) * (n - 2)));
         check("rand_ready_low", 128'(mon_rdy_low), 128'(1));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/window_3x3.md
WINDOW_3X3 -- requirements
Module: window_3x3

Interface
REQ-001 SHALL have parameter DATA_W, default 8: pixel width in bits.
REQ-002 SHALL have parameter SIZE_W, default 9: width of IMG_SIZE_I and of the internal counters.
REQ-003 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port IMG_SIZE_I  input  SIZE_W: square image side N, in pixels.
REQ-006 SHALL have ports row0_i, row1_i, row2_i  input  DATA_W each: one column of three consecutive image rows; row0 is the oldest row, row2 the newest.
REQ-007 SHALL have port valid_i  input  1: the column on row0_i..row2_i is valid this cycle.
REQ-008 SHALL have port ready_o  output  1: the block accepts a column this cycle.
REQ-009 SHALL have port window_o  output  9*DATA_W: 3x3 window, element k=r*3+c at [k*DATA_W +: DATA_W]; r=0 is the oldest row, c=0 the leftmost (oldest) column.
REQ-010 SHALL have port window_valid_o  output  1: window_o holds a valid window this cycle.

Function
REQ-011 A column SHALL be accepted exactly when valid_i and ready_o are both high (a beat).
REQ-012 On each beat, the column registers SHALL shift: c0<=c1, c1<=c2, c2<=new column.
REQ-013 col_cnt SHALL count beats from 0 to N-1 within a row, then wrap to 0; each wrap SHALL increment row_cnt.
REQ-014 window_valid_o SHALL be high in the cycle after a beat taken with col_cnt>=2, and low otherwise; this gives exactly N-2 windows per row and a latency of 1 cycle.
REQ-015 window_o SHALL update only together with window_valid_o high; at all other times it SHALL hold its previous value.
REQ-016 The FSM SHALL have three states:
- IDLE: ready_o=1. N is latched from IMG_SIZE_I on the first beat, which also moves the FSM to RUN.
- RUN: ready_o=1.
- DONE: ready_o=0 for exactly 1 cycle, then return to IDLE with both counters at 0.
REQ-017 RUN->DONE SHALL occur on the beat with col_cnt=N-1 and row_cnt=N-3, i.e. after N-2 row triples and N*(N-2) beats.
REQ-018 Changes on IMG_SIZE_I outside the IDLE first beat SHALL be ignored until the next IDLE.
REQ-019 If the latched N is below 3, beats SHALL be accepted and discarded, window_valid_o SHALL stay 0, and the FSM SHALL stay in IDLE.
REQ-020 Stale columns from the previous row SHALL never appear in a valid window; this is guaranteed by the col_cnt>=2 gating.
REQ-021 valid_i during DONE SHALL be ignored: not accepted and no state change.

Reset
REQ-022 When rst is high at a clock edge:
- FSM goes to IDLE.
- col_cnt, row_cnt and the latched N go to 0.
- Column registers and window_o go to 0.
- window_valid_o goes to 0 and ready_o goes to 1 (frame_done_o to 0 when present).
REQ-023 Reset mid-frame SHALL abandon the frame; the next beat after reset SHALL be treated as column 0, row 0 of a new frame.

Configuration
REQ-024 With macro WINDOW_FRAME_DONE_EN defined, the block SHALL add output frame_done_o (1 bit), high exactly during the DONE cycle.
REQ-025 Without WINDOW_FRAME_DONE_EN, the frame_done_o port SHALL be absent; all other behaviour is identical.

Verification
REQ-026 N=5, feed 15 beats where every pixel equals (row*5+col+1):
- Exactly 9 window_valid_o pulses.
- First window = {1,2,3,6,7,8,11,12,13}, one cycle after beat 3.
REQ-027 N=5, deassert valid_i for 4 cycles between beats 2 and 3:
- No window during the gap.
- First window still {1,2,3,6,7,8,11,12,13}.
REQ-028 N=5, 15 back-to-back beats:
- ready_o low only in the cycle after beat 15.
- frame_done_o pulses there (with macro); FSM back in IDLE.
REQ-029 N=5 latched, then IMG_SIZE_I changed to 7 mid-frame:
- Frame still ends after 15 beats.
- The next frame uses N=7: 35 beats, 25 windows.
REQ-030 N=2: 10 beats produce zero windows and ready_o stays 1.
REQ-031 Assert rst after beat 7 of an N=5 frame:
- All outputs reset on the next cycle.
- A fresh 15-beat frame yields 9 correct windows.
